w80386_prefetch_queue: RTL and testbench
========================================

# w80386_prefetch_queue

Instruction prefetch stage of the w80386 core. Fetches 32-bit words from the core bus, buffers them in a byte-granular circular queue, and presents a 16-byte instruction window to the decode stage. Decode reports how many bytes it consumed; a flush re-steers fetching to a new linear address after jumps, resets, or faults.

## Interface
- QUEUE_BYTES, 32: queue capacity in bytes; power of two, at least 20.
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- flush_valid  in  1  discard the queue and restart fetching at flush_address.
- flush_address  in  32  linear address of the next instruction byte.
- bus_vaild  out  1  read request valid.
- bus_ready  in  1  bus has accepted the request; bus_data is valid in this cycle.
- bus_write_enable  out  1  tied to 0; this block only reads.
- bus_address  out  32  word-aligned read address, bits [1:0] always 0.
- bus_data  in  32  read data, little-endian: byte 0 is bits [7:0].
- instruction  out  8 x [0:15]  window; instruction[i] is queue byte i. Entries at or beyond valid_bytes read 0.
- valid_bytes  out  5  number of valid window bytes, 0..16.
- instruction_address  out  32  linear address of instruction[0].
- consume_valid  in  1  decode retires consume_bytes this cycle.
- consume_bytes  in  4  bytes to pop, 1..15.
- consume_error  out  1  one-cycle pulse when a consume was rejected.

## Operation
- State machine: IDLE, REQUEST, DISCARD.
  - IDLE -> REQUEST when free space (QUEUE_BYTES - count) >= 4. The free-space test uses the count after this cycle's consume.
  - REQUEST: bus_vaild=1. bus_address stays stable until bus_ready is high.
  - On bus_ready without a flush: push the bytes, advance fetch_address by 4 (wraps modulo 2^32), then go to REQUEST if space is still at least 4, otherwise IDLE.
  - A flush while in REQUEST without bus_ready: go to DISCARD. The bus has no abort, so the request is held until bus_ready and its data is dropped, then go to REQUEST at the new address.
- Fill: the first word after a flush pushes only bytes flush_address[1:0]..3. Every later word pushes all 4 bytes.
- Flush sets:
  - count to 0;
  - instruction_address to flush_address;
  - fetch_address to {flush_address[31:2], 2'b00};
  - a skip offset to flush_address[1:0].
- Consume:
  - Accepted only when consume_bytes is between 1 and valid_bytes, inclusive.
  - When accepted: the head advances by consume_bytes, count decreases by consume_bytes, and instruction_address increases by consume_bytes (modulo 2^32).
  - Otherwise the queue is unchanged and consume_error pulses in the next cycle.
- Same-cycle push and pop: count_next = count - popped + pushed. The push lands at the tail computed before the pop.
- Flush has priority over consume and push in the same cycle. A bus_ready arriving in the flush cycle drops its data; the next cycle is REQUEST at the new address.
- Head and tail pointers wrap modulo QUEUE_BYTES. count ranges 0..QUEUE_BYTES. valid_bytes = min(count, 16).
- Reset values (asynchronous, while reset=0):
  - state IDLE; bus_vaild 0; bus_address 0; bus_write_enable 0;
  - count 0; valid_bytes 0; instruction all 0; instruction_address 0; consume_error 0;
  - fetch_address 0; skip offset 0.
- After reset is released, fetching starts at address 0 and continues until a flush. The core issues the reset-vector flush.

## Timing
- Flush in cycle N: bus_vaild=1 with the new address from cycle N+1, unless a request is outstanding (DISCARD).
- bus_ready in cycle M: the pushed bytes are visible in instruction and valid_bytes at M+1.
- Consume in cycle K: the window shifts and instruction_address updates at K+1.
- A request is never issued while free space is below 4. bus_vaild deasserts in the cycle after the transfer that fills the queue.
- Throughput: one word per cycle while bus_ready stays high and space allows.
- Reset asserted mid-transfer: bus_vaild drops immediately (asynchronously). The stale bus_ready is ignored.

## Test plan
- Reset, then flush to 0x0000_1000, bus_ready always 1, memory byte = address[7:0]:
  - bus_address runs 0x1000, 0x1004, … and stops after 8 words (QUEUE_BYTES=32);
  - valid_bytes=16; instruction[0..15] = 0x00..0x0F.
- Flush to 0x0000_2003: the first word pushes 1 byte, so valid_bytes=1 at M+1 with instruction[0]=0x03; instruction_address=0x2003.
- Window full, consume_bytes=5 each cycle while bus_ready=1:
  - count stays consistent: count_next = count - 5 + 4;
  - instruction_address advances by 5 per cycle.
- Flush while bus_ready is held low for 3 cycles:
  - bus_address holds the old address; the DISCARD data is not pushed;
  - the next request carries the new aligned address.
- valid_bytes=3 and consume_bytes=7: the queue is unchanged and consume_error=1 for exactly one cycle.
- Flush to 0xFFFF_FFFC: the fetch address wraps, so the second request is 0x0000_0000.

Source files
------------

// File: rtl/w80386_prefetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : w80386_prefetch_queue_if
// Brief    : Flush, core-bus read and decode-window signals of the prefetch
//            stage, with a prefetch-side (master) and environment-side (slave) view.
// Revision : 1.0 - initial release
// ============================================================================
interface w80386_prefetch_queue_if;
   logic        flush_valid;
   logic [31:0] flush_address;
   logic        bus_vaild;
   logic        bus_ready;
   logic        bus_write_enable;
   logic [31:0] bus_address;
   logic [31:0] bus_data;
   logic [7:0]  instruction [0:15];
   logic [4:0]  valid_bytes;
   logic [31:0] instruction_address;
   logic        consume_valid;
   logic [3:0]  consume_bytes;
   logic        consume_error;

   modport master (
      input  flush_valid, flush_address, bus_ready, bus_data,
             consume_valid, consume_bytes,
      output bus_vaild, bus_write_enable, bus_address, instruction,
             valid_bytes, instruction_address, consume_error
   );

   modport slave (
      output flush_valid, flush_address, bus_ready, bus_data,
             consume_valid, consume_bytes,
      input  bus_vaild, bus_write_enable, bus_address, instruction,
             valid_bytes, instruction_address, consume_error
   );
endinterface
`default_nettype wire

// File: rtl/w80386_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : w80386_prefetch_queue
// Brief    : Byte-granular circular prefetch queue feeding a 16-byte decode
//            window from 32-bit core-bus reads, with flush re-steering.
// Revision : 1.0 - initial release
// ============================================================================
module w80386_prefetch_queue #(
   parameter int QUEUE_BYTES = 32
) (
   input  wire logic               clock,
   input  wire logic               reset,
   w80386_prefetch_queue_if.master bus
);
   localparam int c_ptr_w = $clog2(QUEUE_BYTES);
   localparam int c_cnt_w = c_ptr_w + 1;
   localparam logic [c_cnt_w-1:0] c_space_lim = c_cnt_w'(QUEUE_BYTES - 4);
   localparam logic [c_cnt_w-1:0] c_window    = c_cnt_w'(16);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQUEST = 2'd1,
      DISCARD = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [7:0]         mem_q [QUEUE_BYTES];
   logic [7:0]         mem_d [QUEUE_BYTES];
   logic [c_ptr_w-1:0] head_q, head_d;
   logic [c_ptr_w-1:0] tail_q, tail_d;
   logic [c_cnt_w-1:0] count_q, count_d;
   logic [31:0]        fetch_address_q, fetch_address_d;
   logic [31:0]        bus_address_q, bus_address_d;
   logic [31:0]        instruction_address_q, instruction_address_d;
   logic [1:0]         skip_q, skip_d;
   logic               consume_error_q, consume_error_d;

   logic               w_accept;
   logic               w_push;
   logic [2:0]         w_push_bytes;
   logic [c_cnt_w-1:0] w_pop_cnt;
   logic [c_cnt_w-1:0] w_push_cnt;
   logic [4:0]         w_valid_bytes;
   logic [7:0]         w_window [0:15];

   assign w_valid_bytes = (count_q >= c_window) ? 5'd16 : count_q[4:0];
   assign w_accept      = bus.consume_valid && (bus.consume_bytes != 4'd0) &&
                          ({1'b0, bus.consume_bytes} <= w_valid_bytes);
   assign w_push        = (state_q == REQUEST) && bus.bus_ready;
   assign w_push_bytes  = 3'd4 - {1'b0, skip_q};
   assign w_pop_cnt     = w_accept ? c_cnt_w'(bus.consume_bytes) : '0;
   assign w_push_cnt    = w_push ? c_cnt_w'(w_push_bytes) : '0;

   always_comb begin
      state_d               = state_q;
      mem_d                 = mem_q;
      head_d                = head_q;
      tail_d                = tail_q;
      count_d               = count_q;
      fetch_address_d       = fetch_address_q;
      instruction_address_d = instruction_address_q;
      skip_d                = skip_q;
      consume_error_d       = 1'b0;

      if (bus.flush_valid) begin
         head_d                = '0;
         tail_d                = '0;
         count_d               = '0;
         instruction_address_d = bus.flush_address;
         fetch_address_d       = {bus.flush_address[31:2], 2'b00};
         skip_d                = bus.flush_address[1:0];
         // An outstanding read cannot be aborted; its data must be soaked up first.
         state_d = ((state_q != IDLE) && !bus.bus_ready) ? DISCARD : REQUEST;
      end else begin
         if (w_accept) begin
            head_d                = head_q + c_ptr_w'(bus.consume_bytes);
            instruction_address_d = instruction_address_q + {28'd0, bus.consume_bytes};
         end else if (bus.consume_valid) begin
            consume_error_d = 1'b1;
         end

         if (w_push) begin
            for (int k = 0; k < 4; k++) begin
               if (2'(k) >= skip_q) begin
                  mem_d[tail_q + c_ptr_w'(k) - c_ptr_w'(skip_q)] = bus.bus_data[8*k +: 8];
               end
            end
            tail_d          = tail_q + c_ptr_w'(w_push_bytes);
            fetch_address_d = fetch_address_q + 32'd4;
            skip_d          = 2'd0;
         end

         count_d = count_q - w_pop_cnt + w_push_cnt;

         case (state_q)
            IDLE:    state_d = (count_d <= c_space_lim) ? REQUEST : IDLE;
            REQUEST: if (bus.bus_ready) state_d = (count_d <= c_space_lim) ? REQUEST : IDLE;
            DISCARD: if (bus.bus_ready) state_d = REQUEST;
            default: state_d = IDLE;
         endcase
      end
   end

   // The address of a request being discarded must stay on the bus until it completes.
   assign bus_address_d = (state_d == DISCARD) ? bus_address_q : fetch_address_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q               <= IDLE;
         mem_q                 <= '{default: 8'h00};
         head_q                <= '0;
         tail_q                <= '0;
         count_q               <= '0;
         fetch_address_q       <= '0;
         bus_address_q         <= '0;
         instruction_address_q <= '0;
         skip_q                <= 2'd0;
         consume_error_q       <= 1'b0;
      end else begin
         state_q               <= state_d;
         mem_q                 <= mem_d;
         head_q                <= head_d;
         tail_q                <= tail_d;
         count_q               <= count_d;
         fetch_address_q       <= fetch_address_d;
         bus_address_q         <= bus_address_d;
         instruction_address_q <= instruction_address_d;
         skip_q                <= skip_d;
         consume_error_q       <= consume_error_d;
      end
   end

   always_comb begin
      for (int i = 0; i < 16; i++) begin
         w_window[i] = (5'(i) < w_valid_bytes) ? mem_q[head_q + c_ptr_w'(i)] : 8'h00;
      end
   end

   assign bus.instruction         = w_window;
   assign bus.bus_vaild           = (state_q != IDLE);
   assign bus.bus_write_enable    = 1'b0;
   assign bus.bus_address         = bus_address_q;
   assign bus.valid_bytes         = w_valid_bytes;
   assign bus.instruction_address = instruction_address_q;
   assign bus.consume_error       = consume_error_q;
endmodule
`default_nettype wire

// File: tb/tb_w80386_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_w80386_prefetch_queue
// Brief    : Self-checking bench for the prefetch queue against a byte-queue
//            reference model; memory returns address[7:0] for every byte.
// Revision : 1.0 - initial release
// ============================================================================
module tb_w80386_prefetch_queue;
   localparam int QB = 32;

   logic clock;
   logic reset;
   int   n_checks;
   int   n_fail;

   w80386_prefetch_queue_if bif ();

   w80386_prefetch_queue #(.QUEUE_BYTES(QB)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bif.master)
   );

   always #5 clock = ~clock;

   // Reference model state
   logic [7:0]  mq [$];
   logic [31:0] m_ia;
   logic [31:0] m_fetch;
   logic [31:0] m_disc_addr;
   logic [1:0]  m_skip;
   bit          m_disc;
   bit          m_valid;
   bit          m_err;

   function automatic logic [7:0] mb(input logic [31:0] a);
      return a[7:0];
   endfunction

   task automatic idle_inputs();
      bif.flush_valid   = 1'b0;
      bif.flush_address = 32'h0;
      bif.consume_valid = 1'b0;
      bif.consume_bytes = 4'd0;
      bif.bus_ready     = 1'b0;
      bif.bus_data      = 32'h0;
   endtask

   task automatic model_clear();
      mq.delete();
      m_ia = 0; m_fetch = 0; m_disc_addr = 0; m_skip = 0;
      m_disc = 0; m_valid = 0; m_err = 0;
   endtask

   // One clock: drive inputs, advance the model, then land at posedge+1.
   task automatic step(input bit f, input logic [31:0] fa, input bit cv,
                       input logic [3:0] cb, input bit rdy);
      bit r, acc;
      int vb;
      logic [31:0] req;
      r   = rdy && m_valid;
      req = m_disc ? m_disc_addr : m_fetch;
      bif.flush_valid   = f;
      bif.flush_address = fa;
      bif.consume_valid = cv;
      bif.consume_bytes = cb;
      bif.bus_ready     = r;
      bif.bus_data      = {mb(req + 32'd3), mb(req + 32'd2), mb(req + 32'd1), mb(req)};
      vb  = (mq.size() > 16) ? 16 : mq.size();
      acc = cv && (cb != 0) && (int'(cb) <= vb) && !f;
      m_err = cv && !f && !acc;
      if (f) begin
         mq.delete();
         m_ia    = fa;
         m_fetch = {fa[31:2], 2'b00};
         m_skip  = fa[1:0];
         if (m_valid && !r) begin
            m_disc_addr = req;
            m_disc      = 1;
         end else begin
            m_disc = 0;
         end
      end else begin
         if (acc) begin
            for (int j = 0; j < int'(cb); j++) void'(mq.pop_front());
            m_ia = m_ia + 32'(cb);
         end
         if (r) begin
            if (m_disc) m_disc = 0;
            else begin
               for (int k = int'(m_skip); k < 4; k++) mq.push_back(mb(m_fetch + 32'(k)));
               m_fetch = m_fetch + 32'd4;
               m_skip  = 0;
            end
         end
      end
      m_valid = m_disc || (mq.size() <= QB - 4);
      @(posedge clock);
      #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #1;
      n_checks++; if (bif.bus_vaild !== 1'b0) begin n_fail++; $display("FAIL reset_vaild got %b want 0", bif.bus_vaild); end
      n_checks++; if (bif.bus_address !== 32'h0) begin n_fail++; $display("FAIL reset_address got %h want 0", bif.bus_address); end
      n_checks++; if (bif.valid_bytes !== 5'd0) begin n_fail++; $display("FAIL reset_valid_bytes got %0d want 0", bif.valid_bytes); end
      n_checks++; if (bif.instruction_address !== 32'h0) begin n_fail++; $display("FAIL reset_ia got %h want 0", bif.instruction_address); end
      n_checks++; if (bif.consume_error !== 1'b0 || bif.bus_write_enable !== 1'b0) begin n_fail++; $display("FAIL reset_err_we got %b%b want 00", bif.consume_error, bif.bus_write_enable); end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      model_clear();
      step(0, 0, 0, 0, 0);
      n_checks++; if (bif.bus_vaild !== 1'b1 || bif.bus_address !== 32'h0) begin n_fail++; $display("FAIL reset_first_req got %b/%h want 1/00000000", bif.bus_vaild, bif.bus_address); end
      // Asynchronous reset in the middle of an outstanding request
      bif.bus_ready = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      n_checks++; if (bif.bus_vaild !== 1'b0) begin n_fail++; $display("FAIL reset_async_drop got %b want 0", bif.bus_vaild); end
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      model_clear();
      @(posedge clock); #1;
      bif.bus_ready = 1'b0;
      m_valid = 1;
      n_checks++; if (bif.valid_bytes !== 5'd0 || bif.bus_vaild !== 1'b1) begin n_fail++; $display("FAIL reset_stale_ready got %0d/%b want 0/1", bif.valid_bytes, bif.bus_vaild); end
   endtask

   task automatic test_fill();
      int n;
      n = 0;
      step(1, 32'h0000_1000, 0, 0, 1);
      for (int c = 0; c < 14; c++) begin
         if (bif.bus_vaild === 1'b1) begin
            n_checks++; if (bif.bus_address !== 32'h1000 + 32'(4 * n)) begin n_fail++; $display("FAIL fill_address got %h want %h", bif.bus_address, 32'h1000 + 32'(4 * n)); end
            n++;
         end
         step(0, 0, 0, 0, 1);
      end
      n_checks++; if (n != 8) begin n_fail++; $display("FAIL fill_words got %0d want 8", n); end
      n_checks++; if (bif.valid_bytes !== 5'd16) begin n_fail++; $display("FAIL fill_valid_bytes got %0d want 16", bif.valid_bytes); end
      for (int i = 0; i < 16; i++) begin
         n_checks++; if (bif.instruction[i] !== 8'(i)) begin n_fail++; $display("FAIL fill_byte[%0d] got %h want %h", i, bif.instruction[i], 8'(i)); end
      end
      n_checks++; if (bif.bus_vaild !== 1'b0) begin n_fail++; $display("FAIL fill_stop got %b want 0", bif.bus_vaild); end
   endtask

   task automatic test_unaligned();
      step(1, 32'h0000_2003, 0, 0, 1);
      n_checks++; if (bif.bus_vaild !== 1'b1 || bif.bus_address !== 32'h2000) begin n_fail++; $display("FAIL unal_req got %b/%h want 1/00002000", bif.bus_vaild, bif.bus_address); end
      step(0, 0, 0, 0, 1);
      n_checks++; if (bif.valid_bytes !== 5'd1) begin n_fail++; $display("FAIL unal_valid got %0d want 1", bif.valid_bytes); end
      n_checks++; if (bif.instruction[0] !== 8'h03 || bif.instruction[1] !== 8'h00) begin n_fail++; $display("FAIL unal_bytes got %h %h want 03 00", bif.instruction[0], bif.instruction[1]); end
      n_checks++; if (bif.instruction_address !== 32'h2003) begin n_fail++; $display("FAIL unal_ia got %h want 00002003", bif.instruction_address); end
      step(0, 0, 0, 0, 1);
      n_checks++; if (bif.valid_bytes !== 5'd5 || bif.instruction[1] !== 8'h04) begin n_fail++; $display("FAIL unal_second got %0d/%h want 5/04", bif.valid_bytes, bif.instruction[1]); end
   endtask

   task automatic test_stream();
      step(1, 32'h0000_3000, 0, 0, 1);
      repeat (10) step(0, 0, 0, 0, 1);
      for (int c = 1; c <= 12; c++) begin
         step(0, 0, 1, 4'd5, 1);
         n_checks++; if (bif.instruction_address !== 32'h3000 + 32'(5 * c)) begin n_fail++; $display("FAIL stream_ia got %h want %h", bif.instruction_address, 32'h3000 + 32'(5 * c)); end
         n_checks++; if (bif.consume_error !== 1'b0 || bif.bus_vaild !== 1'b1) begin n_fail++; $display("FAIL stream_flags got %b/%b want 0/1", bif.consume_error, bif.bus_vaild); end
      end
      n_checks++; if (bif.valid_bytes !== 5'd16 || bif.instruction[0] !== 8'h3C) begin n_fail++; $display("FAIL stream_window got %0d/%h want 16/3c", bif.valid_bytes, bif.instruction[0]); end
      n_checks++; if (mq.size() != 16) begin n_fail++; $display("FAIL stream_count got %0d want 16", mq.size()); end
   endtask

   task automatic test_flush_discard();
      step(1, 32'h0000_4000, 0, 0, 1);
      step(0, 0, 0, 0, 0);
      n_checks++; if (bif.bus_address !== 32'h4000) begin n_fail++; $display("FAIL disc_pre got %h want 00004000", bif.bus_address); end
      step(1, 32'h0000_5006, 0, 0, 0);
      for (int c = 0; c < 3; c++) begin
         n_checks++; if (bif.bus_vaild !== 1'b1 || bif.bus_address !== 32'h4000) begin n_fail++; $display("FAIL disc_hold got %b/%h want 1/00004000", bif.bus_vaild, bif.bus_address); end
         if (c < 2) step(0, 0, 0, 0, 0);
      end
      step(0, 0, 0, 0, 1);
      n_checks++; if (bif.valid_bytes !== 5'd0) begin n_fail++; $display("FAIL disc_dropped got %0d want 0", bif.valid_bytes); end
      n_checks++; if (bif.bus_vaild !== 1'b1 || bif.bus_address !== 32'h5004) begin n_fail++; $display("FAIL disc_new_req got %b/%h want 1/00005004", bif.bus_vaild, bif.bus_address); end
      n_checks++; if (bif.instruction_address !== 32'h5006) begin n_fail++; $display("FAIL disc_ia got %h want 00005006", bif.instruction_address); end
      step(0, 0, 0, 0, 1);
      n_checks++; if (bif.valid_bytes !== 5'd2 || bif.instruction[0] !== 8'h06 || bif.instruction[1] !== 8'h07) begin n_fail++; $display("FAIL disc_fill got %0d/%h/%h want 2/06/07", bif.valid_bytes, bif.instruction[0], bif.instruction[1]); end
   endtask

   task automatic test_consume_error();
      step(1, 32'h0000_6001, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      n_checks++; if (bif.valid_bytes !== 5'd3) begin n_fail++; $display("FAIL cerr_setup got %0d want 3", bif.valid_bytes); end
      step(0, 0, 1, 4'd7, 0);
      n_checks++; if (bif.consume_error !== 1'b1) begin n_fail++; $display("FAIL cerr_pulse got %b want 1", bif.consume_error); end
      n_checks++; if (bif.valid_bytes !== 5'd3 || bif.instruction_address !== 32'h6001 || bif.instruction[0] !== 8'h01) begin n_fail++; $display("FAIL cerr_unchanged got %0d/%h/%h want 3/00006001/01", bif.valid_bytes, bif.instruction_address, bif.instruction[0]); end
      step(0, 0, 0, 0, 0);
      n_checks++; if (bif.consume_error !== 1'b0) begin n_fail++; $display("FAIL cerr_one_cycle got %b want 0", bif.consume_error); end
      step(0, 0, 1, 4'd0, 0);
      n_checks++; if (bif.consume_error !== 1'b1) begin n_fail++; $display("FAIL cerr_zero got %b want 1", bif.consume_error); end
      step(0, 0, 1, 4'd3, 0);
      n_checks++; if (bif.consume_error !== 1'b0 || bif.valid_bytes !== 5'd0 || bif.instruction_address !== 32'h6004) begin n_fail++; $display("FAIL cerr_exact got %b/%0d/%h want 0/0/00006004", bif.consume_error, bif.valid_bytes, bif.instruction_address); end
   endtask

   task automatic test_wrap();
      step(1, 32'hFFFF_FFFC, 0, 0, 1);
      n_checks++; if (bif.bus_address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_first got %h want fffffffc", bif.bus_address); end
      step(0, 0, 0, 0, 1);
      n_checks++; if (bif.bus_address !== 32'h0 || bif.instruction[3] !== 8'hFF) begin n_fail++; $display("FAIL wrap_second got %h/%h want 00000000/ff", bif.bus_address, bif.instruction[3]); end
      step(0, 0, 0, 0, 1);
      n_checks++; if (bif.valid_bytes !== 5'd8 || bif.instruction[4] !== 8'h00 || bif.instruction_address !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_fill got %0d/%h/%h want 8/00/fffffffc", bif.valid_bytes, bif.instruction[4], bif.instruction_address); end
      step(0, 0, 1, 4'd6, 0);
      n_checks++; if (bif.instruction_address !== 32'h2 || bif.instruction[0] !== 8'h02) begin n_fail++; $display("FAIL wrap_ia got %h/%h want 00000002/02", bif.instruction_address, bif.instruction[0]); end
   endtask

   task automatic test_random();
      int vb, bad;
      logic [7:0] exp_b, act_b, want_b;
      logic [31:0] exp_a;
      for (int c = 0; c < 1500; c++) begin
         step($urandom_range(0, 39) == 0, $urandom, 1'($urandom_range(0, 1)),
              4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0);
         vb = (mq.size() > 16) ? 16 : mq.size();
         n_checks++; if (bif.bus_vaild !== m_valid) begin n_fail++; $display("FAIL rnd_vaild cyc=%0d got %b want %b", c, bif.bus_vaild, m_valid); end
         exp_a = m_disc ? m_disc_addr : m_fetch;
         if (m_valid) begin
            n_checks++; if (bif.bus_address !== exp_a) begin n_fail++; $display("FAIL rnd_address cyc=%0d got %h want %h", c, bif.bus_address, exp_a); end
         end
         n_checks++; if (bif.valid_bytes !== 5'(vb)) begin n_fail++; $display("FAIL rnd_valid_bytes cyc=%0d got %0d want %0d", c, bif.valid_bytes, vb); end
         n_checks++; if (bif.instruction_address !== m_ia) begin n_fail++; $display("FAIL rnd_ia cyc=%0d got %h want %h", c, bif.instruction_address, m_ia); end
         n_checks++; if (bif.consume_error !== m_err) begin n_fail++; $display("FAIL rnd_consume_error cyc=%0d got %b want %b", c, bif.consume_error, m_err); end
         bad = -1; act_b = 0; want_b = 0;
         for (int i = 0; i < 16; i++) begin
            exp_b = (i < vb) ? mq[i] : 8'h00;
            if (bif.instruction[i] !== exp_b && bad < 0) begin
               bad = i; act_b = bif.instruction[i]; want_b = exp_b;
            end
         end
         n_checks++; if (bad >= 0) begin n_fail++; $display("FAIL rnd_window cyc=%0d byte %0d got %h want %h", c, bad, act_b, want_b); end
      end
      n_checks++; if (bif.bus_write_enable !== 1'b0) begin n_fail++; $display("FAIL rnd_write_enable got %b want 0", bif.bus_write_enable); end
   endtask

   initial begin
      clock = 1'b0;
      reset = 1'b1;
      n_checks = 0;
      n_fail = 0;
      idle_inputs();
      model_clear();
      #1;
      test_reset();
      test_fill();
      test_unaligned();
      test_stream();
      test_flush_discard();
      test_consume_error();
      test_wrap();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
